// File: rtl/pattern_det_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pattern_det_pkg : shared types and helpers for pattern detectors |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pattern_det_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int CNT_W_DEF = 16;
   // Widest pattern any detector built on these helpers may use.
   localparam int PAT_W_MAX = 32;

   typedef logic [$clog2(PAT_W_DEF+1)-1:0] len_t;
   typedef logic [CNT_W_DEF-1:0]           cnt_t;

   function automatic logic [PAT_W_MAX-1:0] len_mask(input int len);
      logic [PAT_W_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < PAT_W_MAX; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Out-of-range lengths fall back to the full pattern width.
   function automatic int len_sanitize(input int len, input int pat_w);
      return (len < 1 || len > pat_w) ? pat_w : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : saturating up-counter, clear+inc in a cycle gives 1 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = inc ? W'(1) : '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pattern_det_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pattern_det_cfg : runtime-loadable serial pattern detector       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pattern_det_cfg
   import pattern_det_pkg::*;
#(
   parameter int               PAT_W   = 8,
   parameter int               CNT_W   = 16,
   parameter logic [PAT_W-1:0] PAT_RST = 8'b0001_0110
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       d_i,
   input  logic                       valid_i,
   input  logic                       pat_load_i,
   input  logic [PAT_W-1:0]           pat_i,
   input  logic [$clog2(PAT_W+1)-1:0] len_i,
   input  logic                       overlap_i,
   input  logic                       cnt_clr_i,
   output logic                       pattern,
   output logic                       pattern_q,
   output logic [CNT_W-1:0]           match_cnt_o
);

   localparam int LEN_W = $clog2(PAT_W+1);

   logic [PAT_W-1:0] pat_q,  pat_d;
   logic [LEN_W-1:0] len_q,  len_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic [PAT_W-2:0] hist_q, hist_d;
   logic             ovl_q,  ovl_d;

   logic [PAT_W-1:0]     cmp;
   logic [PAT_W_MAX-1:0] diff;
   logic                 fill_ok;
   logic                 match;

   always_comb begin
      cmp     = {hist_q, d_i};
      diff    = PAT_W_MAX'(cmp ^ pat_q) & len_mask(int'(len_q));
      fill_ok = (fill_q >= (len_q - LEN_W'(1)));
      match   = valid_i & ~pat_load_i & fill_ok & (diff == '0);

      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;

      if (pat_load_i) begin
         pat_d  = pat_i;
         len_d  = LEN_W'(len_sanitize(int'(len_i), PAT_W));
         ovl_d  = overlap_i;
         hist_d = '0;
         fill_d = '0;
      end else if (valid_i) begin
         hist_d = cmp[PAT_W-2:0];
         // Non-overlap restarts the fill; stale history bits are masked by fill_ok.
         if (match && !ovl_q) begin
            fill_d = '0;
         end else if (fill_q < LEN_W'(PAT_W-1)) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end
   end

   assign pattern = match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q     <= PAT_RST;
         len_q     <= LEN_W'(PAT_W);
         ovl_q     <= 1'b1;
         hist_q    <= '0;
         fill_q    <= '0;
         pattern_q <= 1'b0;
      end else begin
         pat_q     <= pat_d;
         len_q     <= len_d;
         ovl_q     <= ovl_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pattern_q <= match;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (match),
      .clr   (cnt_clr_i),
      .cnt_o (match_cnt_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_pattern_det_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pattern_det_cfg : scoreboard bench for pattern_det_cfg        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pattern_det_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_i, valid_i, pat_load_i, overlap_i, cnt_clr_i;
   logic [7:0] pat_i;
   logic [3:0] len_i;
   logic       pattern, pattern_q, pattern2, pattern_q2;
   logic [15:0] cnt1;
   logic [1:0]  cnt2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit pq;
      int c1;
      int c2;
   } exp_t;
   exp_t sb[$];

   // Reference model: bits received since the last fill restart, newest last.
   bit         mq[$];
   logic [7:0] mpat;
   int         mlen;
   bit         movl;
   int         mc1, mc2;

   always #5 clk = ~clk;

   pattern_det_cfg dut (
      .clk(clk), .rst(rst), .d_i(d_i), .valid_i(valid_i), .pat_load_i(pat_load_i),
      .pat_i(pat_i), .len_i(len_i), .overlap_i(overlap_i), .cnt_clr_i(cnt_clr_i),
      .pattern(pattern), .pattern_q(pattern_q), .match_cnt_o(cnt1)
   );

   pattern_det_cfg #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .d_i(d_i), .valid_i(valid_i), .pat_load_i(pat_load_i),
      .pat_i(pat_i), .len_i(len_i), .overlap_i(overlap_i), .cnt_clr_i(cnt_clr_i),
      .pattern(pattern2), .pattern_q(pattern_q2), .match_cnt_o(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mpat = 8'b0001_0110;
      mlen = 8;
      movl = 1'b1;
      mc1  = 0;
      mc2  = 0;
   endtask

   task automatic cycle(input bit v, input bit d, input bit ld, input logic [7:0] p,
                        input int l, input bit o, input bit clr);
      exp_t e;
      bit   m;
      @(negedge clk);
      valid_i = v; d_i = d; pat_load_i = ld; pat_i = p;
      len_i = 4'(l); overlap_i = o; cnt_clr_i = clr;
      m = 1'b0;
      if (ld) begin
         mpat = p;
         mlen = (l < 1 || l > 8) ? 8 : l;
         movl = o;
         mq.delete();
      end else if (v) begin
         mq.push_back(d);
         if (mq.size() > 8) void'(mq.pop_front());
         if (mq.size() >= mlen) begin
            m = 1'b1;
            for (int k = 0; k < mlen; k++)
               if (mq[mq.size()-1-k] != mpat[k]) m = 1'b0;
         end
         if (m && !movl) mq.delete();
      end
      if (clr) begin
         mc1 = int'(m);
         mc2 = int'(m);
      end else if (m) begin
         if (mc1 < 65535) mc1++;
         if (mc2 < 3) mc2++;
      end
      e.pq = m; e.c1 = mc1; e.c2 = mc2;
      sb.push_back(e);
      #1;
      check("pattern", {31'd0, pattern}, {31'd0, m});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("pattern_q", {31'd0, pattern_q}, {31'd0, e.pq});
      check("match_cnt", {16'd0, cnt1}, e.c1);
      check("match_cnt_w2", {30'd0, cnt2}, e.c2);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] p, input int l, input bit o);
      cycle(1'b0, 1'b0, 1'b1, p, l, o, 1'b1);
   endtask

   task automatic send(input logic [7:0] bits, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         cycle(1'b1, bits[i], 1'b0, 8'h00, 0, 1'b0, 1'b0);
         for (int g = 0; g < gap; g++) idle();
      end
   endtask

   initial begin
      rst = 1'b1;
      d_i = 1'b0; valid_i = 1'b0; pat_load_i = 1'b0; pat_i = '0;
      len_i = '0; overlap_i = 1'b0; cnt_clr_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pattern", {31'd0, pattern}, 32'd0);
      check("rst_pattern_q", {31'd0, pattern_q}, 32'd0);
      check("rst_cnt", {16'd0, cnt1}, 32'd0);
      check("rst_len", {28'd0, dut.len_q}, 32'd8);
      rst = 1'b0;

      // Overlapping: matches on bits 5 and 8.
      load(8'b0001_0110, 5, 1'b1);
      send(8'b1011_0110, 8, 0);
      check("ovl_total", {16'd0, cnt1}, 32'd2);

      // Non-overlapping: only bit 5.
      load(8'b0001_0110, 5, 1'b0);
      send(8'b1011_0110, 8, 0);
      check("novl_total", {16'd0, cnt1}, 32'd1);

      // Valid gaps do not break the sequence.
      load(8'b0001_0110, 5, 1'b1);
      send(8'b0001_0110, 5, 3);
      check("gap_total", {16'd0, cnt1}, 32'd1);

      // Load coincident with the final bit discards it.
      load(8'b0001_0110, 5, 1'b1);
      send(8'b0000_1011, 4, 0);
      cycle(1'b1, 1'b0, 1'b1, 8'b0001_0110, 5, 1'b1, 1'b0);
      check("load_fill", {28'd0, dut.fill_q}, 32'd0);
      send(8'b0001_0110, 5, 0);
      check("load_total", {16'd0, cnt1}, 32'd1);

      // Length 0 and over-range lengths map to the full width.
      load(8'b1011_0010, 12, 1'b1);
      check("len_over", {28'd0, dut.len_q}, 32'd8);
      load(8'b1011_0010, 0, 1'b1);
      check("len_zero", {28'd0, dut.len_q}, 32'd8);
      send(8'b1011_0010, 8, 0);
      check("len8_total", {16'd0, cnt1}, 32'd1);

      // Length 1, non-overlap: every '1' matches.
      load(8'b0000_0001, 1, 1'b0);
      send(8'b0000_1101, 4, 0);
      check("len1_total", {16'd0, cnt1}, 32'd3);

      // Saturation on the narrow counter, then clear coincident with a match.
      load(8'b0000_0001, 1, 1'b1);
      send(8'b0001_1111, 5, 0);
      check("sat_w2", {30'd0, cnt2}, 32'd3);
      check("sat_w16", {16'd0, cnt1}, 32'd5);
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      check("clr_inc", {16'd0, cnt1}, 32'd1);

      // Async reset mid-pattern restores defaults and discards history.
      load(8'b0001_0110, 8, 1'b1);
      send(8'b0000_0001, 4, 0);
      @(negedge clk);
      valid_i = 1'b1; d_i = 1'b0; pat_load_i = 1'b0; cnt_clr_i = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_pattern", {31'd0, pattern}, 32'd0);
      check("arst_pattern_q", {31'd0, pattern_q}, 32'd0);
      check("arst_cnt", {16'd0, cnt1}, 32'd0);
      model_reset();
      #1 rst = 1'b0;
      send(8'b0000_0110, 4, 0);
      send(8'b0001_0110, 8, 0);
      check("arst_total", {16'd0, cnt1}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
